// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default widths, FSM state
// encoding and operand typedefs.
package div_pkg;

  localparam int ARG_BIT_WIDTH = 32;
  localparam int PRECISION     = 64;
  localparam int COUNTER_BITS  = $clog2(PRECISION + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [ARG_BIT_WIDTH-1:0] arg_t;
  typedef logic [PRECISION-1:0]     recip_t;

endpackage

// File: rtl/recip_correct.sv
// Exact-correction step: bumps a truncated quotient by one when it is short,
// then derives the remainder from the final quotient.
module recip_correct #(
  parameter int ARG_BIT_WIDTH = div_pkg::ARG_BIT_WIDTH
) (
  input  logic [ARG_BIT_WIDTH-1:0] q0,
  input  logic [ARG_BIT_WIDTH-1:0] a,
  input  logic [ARG_BIT_WIDTH-1:0] b,
  output logic [ARG_BIT_WIDTH-1:0] quot,
  output logic [ARG_BIT_WIDTH-1:0] rem
);

  // One extra bit keeps q0+1 from wrapping to zero when q0 is all ones.
  logic [ARG_BIT_WIDTH:0]   q1_s;
  logic [2*ARG_BIT_WIDTH:0] prod_s;

  // Trial product of (q0+1)*b against the dividend selects the quotient.
  always_comb begin
    q1_s   = {1'b0, q0} + {{ARG_BIT_WIDTH{1'b0}}, 1'b1};
    prod_s = {{ARG_BIT_WIDTH{1'b0}}, q1_s} * {{(ARG_BIT_WIDTH+1){1'b0}}, b};
    if (prod_s <= {{(ARG_BIT_WIDTH+1){1'b0}}, a}) begin
      quot = q1_s[ARG_BIT_WIDTH-1:0];
    end else begin
      quot = q0;
    end
    rem = a - quot * b;
  end

endmodule

// File: rtl/seq_recip_multiplier.sv
// Consumer half of the sequential divider: multiplies the dividend by a
// bit-weighted reciprocal one bit per cycle, then corrects the quotient.
module seq_recip_multiplier #(
  parameter int ARG_BIT_WIDTH = div_pkg::ARG_BIT_WIDTH,
  parameter int PRECISION     = div_pkg::PRECISION,
  parameter int COUNTER_BITS  = $clog2(PRECISION + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ARG_BIT_WIDTH-1:0] a,
  input  logic [ARG_BIT_WIDTH-1:0] b,
  input  logic [PRECISION-1:0]     recip,
  output logic                     done,
  output logic [ARG_BIT_WIDTH-1:0] quot,
  output logic [ARG_BIT_WIDTH-1:0] rem,
  output logic                     dvz
);
  import div_pkg::*;

  localparam int ACC_W = ARG_BIT_WIDTH + PRECISION;

  state_t                   state_r;
  logic [ARG_BIT_WIDTH-1:0] a_r;
  logic [ARG_BIT_WIDTH-1:0] b_r;
  logic [PRECISION-1:0]     recip_sh_r;
  logic [ACC_W-1:0]         acc_r;
  logic [COUNTER_BITS-1:0]  cnt_r;
  logic [ARG_BIT_WIDTH-1:0] q0_s;
  logic [ARG_BIT_WIDTH-1:0] corr_quot_s;
  logic [ARG_BIT_WIDTH-1:0] corr_rem_s;

  assign q0_s = acc_r[PRECISION-1 +: ARG_BIT_WIDTH];

  recip_correct #(.ARG_BIT_WIDTH(ARG_BIT_WIDTH)) u_recip_correct (
    .q0   (q0_s),
    .a    (a_r),
    .b    (b_r),
    .quot (corr_quot_s),
    .rem  (corr_rem_s)
  );

  // Control FSM, shift-add datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      a_r        <= {ARG_BIT_WIDTH{1'b0}};
      b_r        <= {ARG_BIT_WIDTH{1'b0}};
      recip_sh_r <= {PRECISION{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      cnt_r      <= {COUNTER_BITS{1'b0}};
      done       <= 1'b0;
      dvz        <= 1'b0;
      quot       <= {ARG_BIT_WIDTH{1'b0}};
      rem        <= {ARG_BIT_WIDTH{1'b0}};
    end else if (start) begin
      a_r        <= a;
      b_r        <= b;
      recip_sh_r <= recip;
      acc_r      <= {ACC_W{1'b0}};
      cnt_r      <= {COUNTER_BITS{1'b0}};
      done       <= 1'b0;
      dvz        <= 1'b0;
      state_r    <= (b == {ARG_BIT_WIDTH{1'b0}}) ? DONE : MUL;
    end else begin
      case (state_r)
        MUL: begin
          // Reciprocal bit 0 (integer bit) enters first and ends up at weight 2^(P-1).
          acc_r      <= {acc_r[ACC_W-2:0], 1'b0}
                      + (recip_sh_r[0] ? {{PRECISION{1'b0}}, a_r} : {ACC_W{1'b0}});
          recip_sh_r <= {1'b0, recip_sh_r[PRECISION-1:1]};
          cnt_r      <= cnt_r + {{(COUNTER_BITS-1){1'b0}}, 1'b1};
          if (cnt_r == COUNTER_BITS'(PRECISION - 1)) begin
            state_r <= CORR;
          end
        end
        CORR: begin
          quot    <= corr_quot_s;
          rem     <= corr_rem_s;
          done    <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          // Entering DONE with done low only happens on the divide-by-zero path.
          if (!done) begin
            done <= 1'b1;
            dvz  <= 1'b1;
            quot <= {ARG_BIT_WIDTH{1'b1}};
            rem  <= a_r;
          end
        end
        IDLE: begin
          done <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
